// File: rtl/fifo_rr_scheduler.sv
// Round-robin read scheduler moving NUM_FIFOS source FIFOs into one shared
// destination FIFO, with hysteresis back-pressure from destination occupancy,
// sticky overflow detection and a RESET/INIT/IDLE/ACTIVE/ERROR controller.
module fifo_rr_scheduler #(
    parameter int NUM_FIFOS  = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int HI_DEFAULT = 192,
    parameter int LO_DEFAULT = 64
) (
    input  logic                  clk,
    input  logic                  Reset,
    input  logic                  init,
    input  logic [ADDR_WIDTH:0]   umbral_alto,
    input  logic [ADDR_WIDTH:0]   umbral_bajo,
    input  logic [NUM_FIFOS-1:0]  src_empty,
    input  logic [NUM_FIFOS-1:0]  src_full,
    input  logic [NUM_FIFOS-1:0]  src_push,
    input  logic [ADDR_WIDTH:0]   dst_count,
    output logic [NUM_FIFOS-1:0]  pop,
    output logic [1:0]            sel,
    output logic                  dst_push,
    output logic                  pause,
    output logic [2:0]            state,
    output logic                  error_out,
    output logic                  idle_out
);

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_INIT   = 3'd1,
        S_IDLE   = 3'd2,
        S_ACTIVE = 3'd3,
        S_ERROR  = 3'd4
    } state_t;

    localparam logic [ADDR_WIDTH:0] HI_RST = (ADDR_WIDTH+1)'(HI_DEFAULT);
    localparam logic [ADDR_WIDTH:0] LO_RST = (ADDR_WIDTH+1)'(LO_DEFAULT);

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH:0]    hi_q, hi_d, lo_q, lo_d;
    logic [1:0]             ptr_q, ptr_d;
    logic [1:0]             sel_q, sel_d;
    logic                   dst_push_q, dst_push_d;
    logic                   pause_q, pause_d;
    logic                   error_q, error_d;

    logic [NUM_FIFOS-1:0]   pop_c;
    logic [1:0]             grant;
    logic                   found;
    logic [1:0]             idx;
    logic                   overflow;
    logic [ADDR_WIDTH+1:0]  occ;

    // Overflow is a write into a full source; ignored while held in RESET.
    assign overflow = (|(src_push & src_full)) && (state_q != S_RESET);
    // Occupancy counts the push already in flight so pause engages a cycle early.
    assign occ = {1'b0, dst_count} + (ADDR_WIDTH+2)'(dst_push_q);

    // Round-robin grant: first non-empty source after the last one served.
    always_comb begin
        found = 1'b0;
        grant = 2'd0;
        idx   = 2'd0;
        pop_c = '0;
        for (int k = 1; k <= NUM_FIFOS; k++) begin
            idx = ptr_q + 2'(k);
            if (!found && !src_empty[idx]) begin
                found = 1'b1;
                grant = idx;
            end
        end
        if (state_q == S_ACTIVE && !pause_q && found)
            pop_c[grant] = 1'b1;
    end

    // Controller next state; overflow wins over everything except Reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET:  state_d = S_INIT;
            S_INIT:   if (!init) state_d = S_IDLE;
            S_IDLE:   if (init) state_d = S_INIT;
                      else if (!(&src_empty)) state_d = S_ACTIVE;
            S_ACTIVE: if (init) state_d = S_INIT;
                      else if (&src_empty) state_d = S_IDLE;
            S_ERROR:  state_d = S_ERROR;
            default:  state_d = S_RESET;
        endcase
        if (overflow)
            state_d = S_ERROR;
    end

    // Datapath next state: thresholds, pointer, push/select, pause, error flag.
    always_comb begin
        hi_d       = hi_q;
        lo_d       = lo_q;
        ptr_d      = ptr_q;
        sel_d      = sel_q;
        dst_push_d = |pop_c;
        pause_d    = 1'b0;
        error_d    = error_q | overflow;
        // A bad pair (low not below high) is ignored rather than half-loaded.
        if (state_q == S_INIT && umbral_bajo < umbral_alto) begin
            hi_d = umbral_alto;
            lo_d = umbral_bajo;
        end
        if (|pop_c) begin
            ptr_d = grant;
            sel_d = grant;
        end
        if (state_q == S_ACTIVE || state_q == S_IDLE) begin
            if (occ >= {1'b0, hi_q})
                pause_d = 1'b1;
            else if (occ <= {1'b0, lo_q})
                pause_d = 1'b0;
            else
                pause_d = pause_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q    <= S_RESET;
            hi_q       <= HI_RST;
            lo_q       <= LO_RST;
            ptr_q      <= 2'd3;
            sel_q      <= 2'd0;
            dst_push_q <= 1'b0;
            pause_q    <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            ptr_q      <= ptr_d;
            sel_q      <= sel_d;
            dst_push_q <= dst_push_d;
            pause_q    <= pause_d;
            error_q    <= error_d;
        end
    end

    assign pop       = pop_c;
    assign sel       = sel_q;
    assign dst_push  = dst_push_q;
    assign pause     = pause_q;
    assign state     = state_q;
    assign error_out = error_q;
    assign idle_out  = (state_q == S_IDLE);

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Directed bench for fifo_rr_scheduler: reset, threshold load/reject,
// round-robin order, sparse sources, hysteresis, overflow, reset mid-transfer.
module tb_fifo_rr_scheduler;

    logic       clk = 1'b0;
    logic       Reset, init;
    logic [8:0] umbral_alto, umbral_bajo, dst_count;
    logic [3:0] src_empty, src_full, src_push;
    logic [3:0] pop;
    logic [1:0] sel;
    logic       dst_push, pause, error_out, idle_out;
    logic [2:0] state;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fifo_rr_scheduler dut (
        .clk(clk), .Reset(Reset), .init(init),
        .umbral_alto(umbral_alto), .umbral_bajo(umbral_bajo),
        .src_empty(src_empty), .src_full(src_full), .src_push(src_push),
        .dst_count(dst_count), .pop(pop), .sel(sel), .dst_push(dst_push),
        .pause(pause), .state(state), .error_out(error_out), .idle_out(idle_out)
    );

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset;
        Reset = 1'b1; init = 1'b0;
        umbral_alto = 9'd192; umbral_bajo = 9'd64;
        src_empty = 4'b1111; src_full = 4'b0000; src_push = 4'b0000;
        dst_count = 9'd0;
        tick; tick;
        checks++; if (state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
        checks++; if (pop !== 4'b0000) begin failures++; $display("FAIL reset_pop got=%b exp=0000", pop); end
        checks++; if (sel !== 2'd0) begin failures++; $display("FAIL reset_sel got=%0d exp=0", sel); end
        checks++; if (dst_push !== 1'b0) begin failures++; $display("FAIL reset_dst_push got=%b exp=0", dst_push); end
        checks++; if (pause !== 1'b0) begin failures++; $display("FAIL reset_pause got=%b exp=0", pause); end
        checks++; if (error_out !== 1'b0) begin failures++; $display("FAIL reset_error got=%b exp=0", error_out); end
        checks++; if (idle_out !== 1'b0) begin failures++; $display("FAIL reset_idle got=%b exp=0", idle_out); end
    endtask

    // Inverted pair must be ignored: defaults 192/64 stay in force.
    task automatic test_init_rejected;
        Reset = 1'b0; init = 1'b1;
        umbral_alto = 9'd4; umbral_bajo = 9'd10;
        tick;
        checks++; if (state !== 3'd1) begin failures++; $display("FAIL rej_init_state got=%0d exp=1", state); end
        init = 1'b0;
        tick;
        checks++; if (state !== 3'd2) begin failures++; $display("FAIL rej_idle_state got=%0d exp=2", state); end
        checks++; if (idle_out !== 1'b1) begin failures++; $display("FAIL rej_idle_out got=%b exp=1", idle_out); end
        dst_count = 9'd100; tick;
        checks++; if (pause !== 1'b0) begin failures++; $display("FAIL rej_pause_100 got=%b exp=0", pause); end
        dst_count = 9'd192; tick;
        checks++; if (pause !== 1'b1) begin failures++; $display("FAIL rej_pause_192 got=%b exp=1", pause); end
        dst_count = 9'd65; tick;
        checks++; if (pause !== 1'b1) begin failures++; $display("FAIL rej_pause_65 got=%b exp=1", pause); end
        dst_count = 9'd64; tick;
        checks++; if (pause !== 1'b0) begin failures++; $display("FAIL rej_pause_64 got=%b exp=0", pause); end
        dst_count = 9'd0;
    endtask

    task automatic test_init_load;
        Reset = 1'b1; umbral_alto = 9'd10; umbral_bajo = 9'd4;
        tick;
        checks++; if (state !== 3'd0) begin failures++; $display("FAIL load_state0a got=%0d exp=0", state); end
        tick;
        checks++; if (state !== 3'd0) begin failures++; $display("FAIL load_state0b got=%0d exp=0", state); end
        Reset = 1'b0; init = 1'b1;
        tick;
        checks++; if (state !== 3'd1) begin failures++; $display("FAIL load_state1 got=%0d exp=1", state); end
        init = 1'b0;
        tick;
        checks++; if (state !== 3'd2) begin failures++; $display("FAIL load_state2 got=%0d exp=2", state); end
        dst_count = 9'd9; tick;
        checks++; if (pause !== 1'b0) begin failures++; $display("FAIL load_pause_9 got=%b exp=0", pause); end
        dst_count = 9'd10; tick;
        checks++; if (pause !== 1'b1) begin failures++; $display("FAIL load_pause_10 got=%b exp=1", pause); end
        dst_count = 9'd5; tick;
        checks++; if (pause !== 1'b1) begin failures++; $display("FAIL load_pause_5 got=%b exp=1", pause); end
        dst_count = 9'd4; tick;
        checks++; if (pause !== 1'b0) begin failures++; $display("FAIL load_pause_4 got=%b exp=0", pause); end
        dst_count = 9'd0;
    endtask

    task automatic test_rr_all;
        logic [3:0] exp_pop;
        logic [1:0] exp_sel;
        src_empty = 4'b0000;
        tick;
        checks++; if (state !== 3'd3) begin failures++; $display("FAIL rr_active got=%0d exp=3", state); end
        for (int k = 0; k < 5; k++) begin
            exp_pop = 4'b0001 << (k % 4);
            exp_sel = 2'(k % 4);
            checks++; if (pop !== exp_pop) begin failures++; $display("FAIL rr_pop[%0d] got=%b exp=%b", k, pop, exp_pop); end
            tick;
            checks++; if (dst_push !== 1'b1) begin failures++; $display("FAIL rr_push[%0d] got=%b exp=1", k, dst_push); end
            checks++; if (sel !== exp_sel) begin failures++; $display("FAIL rr_sel[%0d] got=%0d exp=%0d", k, sel, exp_sel); end
        end
    endtask

    task automatic test_rr_sparse;
        logic [3:0] exp_pop;
        logic [1:0] exp_sel;
        src_empty = 4'b0101;
        #1;
        for (int j = 0; j < 4; j++) begin
            exp_pop = (j % 2 == 0) ? 4'b0010 : 4'b1000;
            exp_sel = (j % 2 == 0) ? 2'd1 : 2'd3;
            checks++; if (pop !== exp_pop) begin failures++; $display("FAIL sparse_pop[%0d] got=%b exp=%b", j, pop, exp_pop); end
            checks++; if ((pop & src_empty) !== 4'b0000) begin failures++; $display("FAIL sparse_empty_pop[%0d] got=%b exp=0000", j, pop & src_empty); end
            tick;
            checks++; if (sel !== exp_sel) begin failures++; $display("FAIL sparse_sel[%0d] got=%0d exp=%0d", j, sel, exp_sel); end
        end
        src_empty = 4'b1111;
        #1;
        checks++; if (pop !== 4'b0000) begin failures++; $display("FAIL sparse_allempty_pop got=%b exp=0000", pop); end
        tick;
        checks++; if (state !== 3'd2) begin failures++; $display("FAIL sparse_idle got=%0d exp=2", state); end
        checks++; if (idle_out !== 1'b1) begin failures++; $display("FAIL sparse_idle_out got=%b exp=1", idle_out); end
    endtask

    // Thresholds 10/4; occupancy includes the in-flight push, so the
    // pause trips at dst_count=9 while pushes are streaming.
    task automatic test_backpressure;
        logic exp_p;
        dst_count = 9'd0; src_empty = 4'b0000;
        tick;
        checks++; if (state !== 3'd3) begin failures++; $display("FAIL bp_active got=%0d exp=3", state); end
        for (int c = 1; c <= 10; c++) begin
            dst_count = 9'(c);
            tick;
            exp_p = (c >= 9);
            checks++; if (pause !== exp_p) begin failures++; $display("FAIL bp_up_pause[%0d] got=%b exp=%b", c, pause, exp_p); end
            if (exp_p) begin
                checks++; if (pop !== 4'b0000) begin failures++; $display("FAIL bp_up_pop[%0d] got=%b exp=0000", c, pop); end
            end
        end
        for (int c = 9; c >= 4; c--) begin
            dst_count = 9'(c);
            tick;
            exp_p = (c > 4);
            checks++; if (pause !== exp_p) begin failures++; $display("FAIL bp_dn_pause[%0d] got=%b exp=%b", c, pause, exp_p); end
            if (exp_p) begin
                checks++; if (pop !== 4'b0000) begin failures++; $display("FAIL bp_dn_pop[%0d] got=%b exp=0000", c, pop); end
            end
        end
        checks++; if (pop === 4'b0000) begin failures++; $display("FAIL bp_resume_pop got=%b exp=nonzero", pop); end
    endtask

    task automatic test_overflow;
        src_push = 4'b0100; src_full = 4'b0100;
        tick;
        checks++; if (state !== 3'd4) begin failures++; $display("FAIL ovf_state got=%0d exp=4", state); end
        checks++; if (error_out !== 1'b1) begin failures++; $display("FAIL ovf_error got=%b exp=1", error_out); end
        checks++; if (pop !== 4'b0000) begin failures++; $display("FAIL ovf_pop got=%b exp=0000", pop); end
        checks++; if (dst_push !== 1'b1) begin failures++; $display("FAIL ovf_pending_push got=%b exp=1", dst_push); end
        src_push = 4'b0000; src_full = 4'b0000; init = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            checks++; if (state !== 3'd4) begin failures++; $display("FAIL ovf_hold_state[%0d] got=%0d exp=4", i, state); end
            checks++; if (error_out !== 1'b1) begin failures++; $display("FAIL ovf_hold_error[%0d] got=%b exp=1", i, error_out); end
            checks++; if (pop !== 4'b0000) begin failures++; $display("FAIL ovf_hold_pop[%0d] got=%b exp=0000", i, pop); end
            checks++; if (dst_push !== 1'b0) begin failures++; $display("FAIL ovf_hold_push[%0d] got=%b exp=0", i, dst_push); end
            checks++; if (pause !== 1'b0) begin failures++; $display("FAIL ovf_hold_pause[%0d] got=%b exp=0", i, pause); end
        end
        init = 1'b0; Reset = 1'b1;
        tick;
        checks++; if (state !== 3'd0) begin failures++; $display("FAIL ovf_reset_state got=%0d exp=0", state); end
        checks++; if (error_out !== 1'b0) begin failures++; $display("FAIL ovf_reset_error got=%b exp=0", error_out); end
    endtask

    task automatic test_reset_midxfer;
        Reset = 1'b0; src_empty = 4'b0000; dst_count = 9'd0;
        tick;
        checks++; if (state !== 3'd1) begin failures++; $display("FAIL mid_init got=%0d exp=1", state); end
        tick;
        checks++; if (state !== 3'd2) begin failures++; $display("FAIL mid_idle got=%0d exp=2", state); end
        tick;
        checks++; if (state !== 3'd3) begin failures++; $display("FAIL mid_active got=%0d exp=3", state); end
        checks++; if (pop !== 4'b0001) begin failures++; $display("FAIL mid_first_pop got=%b exp=0001", pop); end
        Reset = 1'b1;
        tick;
        checks++; if (dst_push !== 1'b0) begin failures++; $display("FAIL mid_dropped_push got=%b exp=0", dst_push); end
        checks++; if (state !== 3'd0) begin failures++; $display("FAIL mid_state got=%0d exp=0", state); end
        checks++; if (pop !== 4'b0000) begin failures++; $display("FAIL mid_pop got=%b exp=0000", pop); end
    endtask

    initial begin
        test_reset;
        test_init_rejected;
        test_init_load;
        test_rr_all;
        test_rr_sparse;
        test_backpressure;
        test_overflow;
        test_reset_midxfer;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
